// File: rtl/mux_channel_select_reg.sv
// Registered N-channel stream multiplexer with per-channel valid/ready,
// selection by sel (MODE=0) or round-robin (MODE=1), and optional inversion.
module mux_channel_select_reg #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int MODE = 0,
    parameter int SW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [SW-1:0]     sel,
    input  logic              inv,
    input  logic [N_CH-1:0]   in_valid,
    input  logic [N_CH*W-1:0] in_data,
    output logic [N_CH-1:0]   in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic [SW-1:0]     out_ch,
    input  logic              out_ready
);

    logic [SW-1:0] ptr_reg;
    logic [SW-1:0] ptr_next;
    logic [SW-1:0] grant_ch;
    logic          grant;
    logic          load;
    logic [W-1:0]  grant_word;
    int            scan_idx;
    int            next_idx;

    assign load = !out_valid || out_ready;

    always_comb begin
        grant    = 1'b0;
        grant_ch = '0;
        scan_idx = 0;
        if (MODE == 0) begin
            // Compare against every legal channel so an out-of-range sel never grants.
            for (int k = 0; k < N_CH; k++) begin
                if ((int'(sel) == k) && in_valid[k]) begin
                    grant    = 1'b1;
                    grant_ch = SW'(k);
                end
            end
        end else begin
            // Scan from the far end back to ptr so the closest valid channel wins.
            for (int off = N_CH - 1; off >= 0; off--) begin
                scan_idx = int'(ptr_reg) + off;
                if (scan_idx >= N_CH) begin
                    scan_idx = scan_idx - N_CH;
                end
                if (in_valid[scan_idx]) begin
                    grant    = 1'b1;
                    grant_ch = SW'(scan_idx);
                end
            end
        end
    end

    always_comb begin
        next_idx = int'(grant_ch) + 1;
        if (next_idx >= N_CH) begin
            next_idx = 0;
        end
        ptr_next = SW'(next_idx);
    end

    assign grant_word = in_data[int'(grant_ch)*W +: W];

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ready
            assign in_ready[gi] = rst_n && load && grant && (int'(grant_ch) == gi);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr_reg   <= '0;
        end else if (load) begin
            if (grant) begin
                out_valid <= 1'b1;
                out_data  <= inv ? ~grant_word : grant_word;
                out_ch    <= grant_ch;
                if (MODE == 1) begin
                    ptr_reg <= ptr_next;
                end
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_channel_select_reg.sv
// Directed bench: sel mode (4 and 3 channels) and round-robin mode (4 channels)
// instances share clock and reset; each task checks its own expected values.
module tb_mux_channel_select_reg;

    logic clk;
    logic rst_n;

    // MODE=0, N_CH=4
    logic [1:0]  sel0;
    logic        inv0;
    logic [3:0]  iv0;
    logic [31:0] id0;
    logic [3:0]  ir0;
    logic        ov0;
    logic [7:0]  od0;
    logic [1:0]  oc0;
    logic        ordy0;

    // MODE=1, N_CH=4
    logic [1:0]  sel1;
    logic        inv1;
    logic [3:0]  iv1;
    logic [31:0] id1;
    logic [3:0]  ir1;
    logic        ov1;
    logic [7:0]  od1;
    logic [1:0]  oc1;
    logic        ordy1;

    // MODE=0, N_CH=3
    logic [1:0]  sel3;
    logic        inv3;
    logic [2:0]  iv3;
    logic [23:0] id3;
    logic [2:0]  ir3;
    logic        ov3;
    logic [7:0]  od3;
    logic [1:0]  oc3;
    logic        ordy3;

    int vectors;
    int miscompares;

    mux_channel_select_reg #(.N_CH(4), .W(8), .MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sel(sel0), .inv(inv0), .in_valid(iv0),
        .in_data(id0), .in_ready(ir0), .out_valid(ov0), .out_data(od0),
        .out_ch(oc0), .out_ready(ordy0)
    );

    mux_channel_select_reg #(.N_CH(4), .W(8), .MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .sel(sel1), .inv(inv1), .in_valid(iv1),
        .in_data(id1), .in_ready(ir1), .out_valid(ov1), .out_data(od1),
        .out_ch(oc1), .out_ready(ordy1)
    );

    mux_channel_select_reg #(.N_CH(3), .W(8), .MODE(0)) dut3 (
        .clk(clk), .rst_n(rst_n), .sel(sel3), .inv(inv3), .in_valid(iv3),
        .in_data(id3), .in_ready(ir3), .out_valid(ov3), .out_data(od3),
        .out_ch(oc3), .out_ready(ordy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel0 = 2'd1; inv0 = 1'b0; iv0 = 4'hF; id0 = 32'h44332211; ordy0 = 1'b1;
        #1;
        vectors++;
        if ({ov0, od0, oc0} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_init outputs got v=%0b d=%h ch=%0d required 0/00/0", ov0, od0, oc0);
        end
        vectors++;
        if (ir0 !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_init in_ready got %b required 0000", ir0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        vectors++;
        if (ir0 !== 4'b0010) begin
            miscompares++;
            $display("FAIL reset_release in_ready got %b required 0010", ir0);
        end
        tick();
        $display("reset: transfer ch=%0d data=%h", oc0, od0);
        vectors++;
        if (ov0 !== 1'b1 || od0 !== 8'h22 || oc0 !== 2'd1) begin
            miscompares++;
            $display("FAIL reset_pre_xfer got v=%0b d=%h ch=%0d required 1/22/1", ov0, od0, oc0);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({ov0, od0, oc0} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_midstream got v=%0b d=%h ch=%0d required 0/00/0", ov0, od0, oc0);
        end
        tick();
        vectors++;
        if (ir0 !== 4'b0000 || ov0 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held got in_ready=%b v=%0b required 0000/0", ir0, ov0);
        end
        iv0 = 4'h0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sel_inv();
        id0 = {8'h44, 8'hA5, 8'h22, 8'h11};
        sel0 = 2'd2; inv0 = 1'b1; iv0 = 4'b0101; ordy0 = 1'b1;
        #1;
        vectors++;
        if (ir0 !== 4'b0100) begin
            miscompares++;
            $display("FAIL sel_inv in_ready got %b required 0100", ir0);
        end
        tick();
        $display("sel_inv: transfer ch=%0d data=%h", oc0, od0);
        vectors++;
        if (ov0 !== 1'b1 || od0 !== 8'h5A || oc0 !== 2'd2) begin
            miscompares++;
            $display("FAIL sel_inv out got v=%0b d=%h ch=%0d required 1/5a/2", ov0, od0, oc0);
        end
        sel0 = 2'd0; inv0 = 1'b0;
        #1;
        vectors++;
        if (ir0 !== 4'b0001) begin
            miscompares++;
            $display("FAIL sel_b2b in_ready got %b required 0001", ir0);
        end
        tick();
        $display("sel_b2b: transfer ch=%0d data=%h", oc0, od0);
        vectors++;
        if (ov0 !== 1'b1 || od0 !== 8'h11 || oc0 !== 2'd0) begin
            miscompares++;
            $display("FAIL sel_b2b out got v=%0b d=%h ch=%0d required 1/11/0", ov0, od0, oc0);
        end
        sel0 = 2'd1;
        #1;
        vectors++;
        if (ir0 !== 4'b0000) begin
            miscompares++;
            $display("FAIL sel_invalid in_ready got %b required 0000", ir0);
        end
        tick();
        vectors++;
        if (ov0 !== 1'b0 || od0 !== 8'h11) begin
            miscompares++;
            $display("FAIL sel_drain got v=%0b d=%h required 0/11", ov0, od0);
        end
        iv0 = 4'h0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch;
        id1 = 32'h13121110;
        iv1 = 4'hF; ordy1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_ch = 2'(i % 4);
            tick();
            $display("rr: cycle %0d ch=%0d data=%h", i, oc1, od1);
            vectors++;
            if (ov1 !== 1'b1 || oc1 !== exp_ch || od1 !== (8'h10 + 8'(i % 4))) begin
                miscompares++;
                $display("FAIL rr_seq[%0d] got v=%0b ch=%0d d=%h required 1/%0d/%h",
                         i, ov1, oc1, od1, exp_ch, 8'h10 + 8'(i % 4));
            end
        end
    endtask

    task automatic test_wrap();
        // ptr is back at 0 after eight round-robin words; walk it to 3.
        iv1 = 4'b0100;
        #1;
        vectors++;
        if (ir1 !== 4'b0100) begin
            miscompares++;
            $display("FAIL wrap_setup in_ready got %b required 0100", ir1);
        end
        tick();
        iv1 = 4'b0010;
        #1;
        vectors++;
        if (ir1 !== 4'b0010) begin
            miscompares++;
            $display("FAIL wrap_grant in_ready got %b required 0010", ir1);
        end
        tick();
        $display("wrap: transfer ch=%0d data=%h", oc1, od1);
        vectors++;
        if (ov1 !== 1'b1 || oc1 !== 2'd1 || od1 !== 8'h11) begin
            miscompares++;
            $display("FAIL wrap_out got v=%0b ch=%0d d=%h required 1/1/11", ov1, oc1, od1);
        end
        iv1 = 4'b0000;
        tick();
        vectors++;
        if (ov1 !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_drain out_valid got %0b required 0", ov1);
        end
        iv1 = 4'hF;
        #1;
        vectors++;
        if (ir1 !== 4'b0100) begin
            miscompares++;
            $display("FAIL wrap_ptr in_ready got %b required 0100", ir1);
        end
        tick();
    endtask

    task automatic test_backpressure();
        // Holding ch2 word; ptr now 3.
        ordy1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (ir1 !== 4'b0000) begin
                miscompares++;
                $display("FAIL bp_ready[%0d] got %b required 0000", i, ir1);
            end
            tick();
            vectors++;
            if (ov1 !== 1'b1 || oc1 !== 2'd2 || od1 !== 8'h12) begin
                miscompares++;
                $display("FAIL bp_hold[%0d] got v=%0b ch=%0d d=%h required 1/2/12", i, ov1, oc1, od1);
            end
        end
        ordy1 = 1'b1;
        #1;
        vectors++;
        if (ir1 !== 4'b1000) begin
            miscompares++;
            $display("FAIL bp_resume in_ready got %b required 1000", ir1);
        end
        tick();
        $display("bp: resume ch=%0d data=%h", oc1, od1);
        vectors++;
        if (ov1 !== 1'b1 || oc1 !== 2'd3 || od1 !== 8'h13) begin
            miscompares++;
            $display("FAIL bp_resume_out got v=%0b ch=%0d d=%h required 1/3/13", ov1, oc1, od1);
        end
        iv1 = 4'h0;
        tick();
    endtask

    task automatic test_no_grant();
        id3 = 24'hCCBBAA;
        sel3 = 2'd3; inv3 = 1'b0; iv3 = 3'b111; ordy3 = 1'b1;
        #1;
        vectors++;
        if (ir3 !== 3'b000) begin
            miscompares++;
            $display("FAIL nogrant in_ready got %b required 000", ir3);
        end
        tick();
        vectors++;
        if (ov3 !== 1'b0) begin
            miscompares++;
            $display("FAIL nogrant out_valid got %0b required 0", ov3);
        end
        sel3 = 2'd2;
        #1;
        vectors++;
        if (ir3 !== 3'b100) begin
            miscompares++;
            $display("FAIL sel3_grant in_ready got %b required 100", ir3);
        end
        tick();
        $display("n3: transfer ch=%0d data=%h", oc3, od3);
        vectors++;
        if (ov3 !== 1'b1 || oc3 !== 2'd2 || od3 !== 8'hCC) begin
            miscompares++;
            $display("FAIL sel3_out got v=%0b ch=%0d d=%h required 1/2/cc", ov3, oc3, od3);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        sel1 = 2'd0; inv1 = 1'b0; iv1 = 4'h0; id1 = 32'h0; ordy1 = 1'b1;
        sel3 = 2'd0; inv3 = 1'b0; iv3 = 3'b0; id3 = 24'h0; ordy3 = 1'b1;
        test_reset();
        test_sel_inv();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_no_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
